counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter: MAX_CNT, default 15, upper occupancy limit (1..15) at which increments are refused.
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: up_req  input  1  increment request, held high until up_gnt seen.
REQ-005 SHALL have port: down_req  input  1  decrement request, held high until down_gnt seen.
REQ-006 SHALL have port: par_out  input  4  current value of the shared 4-bit up/down counter.
REQ-007 SHALL have port: up_gnt  output  1  one-cycle grant pulse to the increment requester.
REQ-008 SHALL have port: down_gnt  output  1  one-cycle grant pulse to the decrement requester.
REQ-009 SHALL have port: up_cnt_en  output  1  increment enable driven to the counter.
REQ-010 SHALL have port: down_cnt_en  output  1  decrement enable driven to the counter.
REQ-011 SHALL have port: full  output  1  high when par_out == MAX_CNT.
REQ-012 SHALL have port: empty  output  1  high when par_out == 0.
REQ-013 SHALL have port: busy  output  1  high whenever FSM not in IDLE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, GRANT, SETTLE.
REQ-015 SHALL define up_elig = up_req & ~full and down_elig = down_req & ~empty, both evaluated in IDLE.
REQ-016 SHALL, in IDLE with exactly one eligible request, move to GRANT serving that direction on the next edge.
REQ-017 SHALL, in IDLE with both eligible, grant the direction opposite to the last-served one (round-robin), updating last-served on entry to GRANT.
REQ-018 SHALL stay in IDLE when neither request is eligible; a blocked request stays pending with no grant.
REQ-019 SHALL, in GRANT, drive the selected gnt and matching cnt_en high for exactly one cycle from registered outputs, the other pair low.
REQ-020 SHALL move GRANT -> SETTLE unconditionally, and SETTLE -> IDLE unconditionally; requests ignored in GRANT and SETTLE.
REQ-021 SHALL never assert up_cnt_en and down_cnt_en in the same cycle.
REQ-022 SHALL give grant latency of one cycle from eligible request in IDLE and minimum spacing of three cycles between grants.
REQ-023 SHALL derive full and empty combinationally from par_out; MAX_CNT == 15 makes 15 the wrap-free ceiling, counter never wraps 15->0 or 0->15 under this controller.

Reset
REQ-024 SHALL, on rst low, asynchronously force state IDLE, last-served = DOWN (so UP wins first tie), and up_gnt, down_gnt, up_cnt_en, down_cnt_en, busy low.
REQ-025 SHALL, on rst assertion mid-GRANT, drop cnt_en within the reset, no partial count issued after release.
REQ-026 SHALL resume evaluation in IDLE on the first rising clk edge after rst deasserts.

Configuration
REQ-027 SHALL, with COUNTER_CTRL_ERR_EN defined, add output err (1 bit) set sticky when in IDLE up_req & full or down_req & empty, cleared only by rst.
REQ-028 SHALL, without COUNTER_CTRL_ERR_EN, omit the err port and its logic; all other behaviour identical.

Verification
REQ-029 SHALL cover: par_out=3, up_req pulse held -> up_gnt and up_cnt_en high one cycle after, busy high 2 cycles, next grant no earlier than 3 cycles.
REQ-030 SHALL cover: after reset both reqs held with par_out=5 -> grant order UP, DOWN, UP, DOWN.
REQ-031 SHALL cover: par_out=15, MAX_CNT=15, up_req held -> no up_gnt, full=1, err=1 when ERR_EN defined.
REQ-032 SHALL cover: par_out=0, both reqs -> down blocked, up granted, empty=1 during request.
REQ-033 SHALL cover: rst low during GRANT -> all outputs low immediately, state IDLE, first tie after release goes UP.
REQ-034 SHALL cover: random reqs 1000 cycles with counter model -> up_cnt_en & down_cnt_en never both 1, par_out stays in 0..MAX_CNT.

Source files
------------

// File: rtl/counter_ctrl_if.sv
// Bundles the request/grant handshake, counter enables and status flags.
// master: the requester/counter side (drives requests and par_out).
// slave:  the controller side (drives grants, enables and status).
// Optional err flag is present only when COUNTER_CTRL_ERR_EN is defined.
interface counter_ctrl_if;
  logic       up_req;
  logic       down_req;
  logic [3:0] par_out;
  logic       up_gnt;
  logic       down_gnt;
  logic       up_cnt_en;
  logic       down_cnt_en;
  logic       full;
  logic       empty;
  logic       busy;
`ifdef COUNTER_CTRL_ERR_EN
  logic       err;

  modport master (
    output up_req, down_req, par_out,
    input  up_gnt, down_gnt, up_cnt_en, down_cnt_en, full, empty, busy, err
  );

  modport slave (
    input  up_req, down_req, par_out,
    output up_gnt, down_gnt, up_cnt_en, down_cnt_en, full, empty, busy, err
  );
`else
  modport master (
    output up_req, down_req, par_out,
    input  up_gnt, down_gnt, up_cnt_en, down_cnt_en, full, empty, busy
  );

  modport slave (
    input  up_req, down_req, par_out,
    output up_gnt, down_gnt, up_cnt_en, down_cnt_en, full, empty, busy
  );
`endif
endinterface

// File: rtl/counter_ctrl.sv
// Arbiter for a shared 4-bit up/down counter. Grants one increment or
// decrement per three-cycle IDLE -> GRANT -> SETTLE round, refusing
// increments at MAX_CNT and decrements at zero; ties alternate.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   bus   - counter_ctrl_if.slave: up_req/down_req/par_out in;
//           up_gnt/down_gnt/up_cnt_en/down_cnt_en/busy (registered) and
//           full/empty (combinational from par_out) out
// Build option: COUNTER_CTRL_ERR_EN adds sticky bus.err, set when a
// request arrives in IDLE against a full/empty counter.
module counter_ctrl #(
  parameter int unsigned MAX_CNT = 15
) (
  input  logic          clk,
  input  logic          rst,
  counter_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_up_q, last_up_d;
  logic   up_gnt_q, up_gnt_d;
  logic   down_gnt_q, down_gnt_d;
  logic   busy_q, busy_d;
  logic   up_elig, down_elig;

  // Status flags follow the counter value directly
  assign bus.full  = (bus.par_out == MAX_VAL);
  assign bus.empty = (bus.par_out == '0);

  assign up_elig   = bus.up_req & ~bus.full;
  assign down_elig = bus.down_req & ~bus.empty;

  // Next state and next registered outputs; outputs reflect state_d so
  // that grant/enable are high exactly while in GRANT
  always_comb begin
    state_d    = state_q;
    last_up_d  = last_up_q;
    up_gnt_d   = 1'b0;
    down_gnt_d = 1'b0;
    busy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Up wins when alone or when down was served last
        if (up_elig && (!down_elig || !last_up_q)) begin
          state_d   = GRANT;
          last_up_d = 1'b1;
          up_gnt_d  = 1'b1;
        end else if (down_elig) begin
          state_d    = GRANT;
          last_up_d  = 1'b0;
          down_gnt_d = 1'b1;
        end
      end
      GRANT:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_up_q  <= 1'b0;
      up_gnt_q   <= 1'b0;
      down_gnt_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_up_q  <= last_up_d;
      up_gnt_q   <= up_gnt_d;
      down_gnt_q <= down_gnt_d;
      busy_q     <= busy_d;
    end
  end

  // Counter enables share the grant registers, so they can never overlap
  assign bus.up_gnt      = up_gnt_q;
  assign bus.down_gnt    = down_gnt_q;
  assign bus.up_cnt_en   = up_gnt_q;
  assign bus.down_cnt_en = down_gnt_q;
  assign bus.busy        = busy_q;

`ifdef COUNTER_CTRL_ERR_EN
  logic err_q, err_d;

  // Sticky flag for requests made against a saturated counter
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE &&
        ((bus.up_req & bus.full) | (bus.down_req & bus.empty)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed and random checks for counter_ctrl with an external counter model.
module tb_counter_ctrl;

  logic       clk;
  logic       rst;
  logic       use_model;
  logic [3:0] par_fixed;
  logic [4:0] model_cnt;
  int         checks;
  int         errors;

  counter_ctrl_if bus ();

  counter_ctrl #(.MAX_CNT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.par_out = use_model ? model_cnt[3:0] : par_fixed;

  // Counter model driven by the controller's enables
  always @(posedge clk) begin
    if (!use_model)            model_cnt <= 5'd7;
    else if (bus.up_cnt_en)    model_cnt <= model_cnt + 5'd1;
    else if (bus.down_cnt_en)  model_cnt <= model_cnt - 5'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.up_req   = 1'b0;
    bus.down_req = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic check_outs(input string tag, input logic ug, input logic dg, input logic bz);
    check({tag, "_up_gnt"},   32'(bus.up_gnt),      32'(ug));
    check({tag, "_up_en"},    32'(bus.up_cnt_en),   32'(ug));
    check({tag, "_down_gnt"}, 32'(bus.down_gnt),    32'(dg));
    check({tag, "_down_en"},  32'(bus.down_cnt_en), 32'(dg));
    check({tag, "_busy"},     32'(bus.busy),        32'(bz));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    use_model    = 1'b0;
    par_fixed    = 4'd3;
    bus.up_req   = 1'b0;
    bus.down_req = 1'b0;
    rst          = 1'b1;
    #2;
    do_reset();
    check_outs("reset", 1'b0, 1'b0, 1'b0);
`ifdef COUNTER_CTRL_ERR_EN
    check("reset_err", 32'(bus.err), 32'd0);
`endif

    // Single up request at par_out=3: one-cycle latency, 3-cycle spacing
    par_fixed  = 4'd3;
    bus.up_req = 1'b1;
    #1;
    check("p3_full",  32'(bus.full),  32'd0);
    check("p3_empty", 32'(bus.empty), 32'd0);
    tick(); check_outs("up_c1", 1'b1, 1'b0, 1'b1);
    tick(); check_outs("up_c2", 1'b0, 1'b0, 1'b1);
    tick(); check_outs("up_c3", 1'b0, 1'b0, 1'b0);
    tick(); check_outs("up_c4", 1'b1, 1'b0, 1'b1);
    bus.up_req = 1'b0;
    tick(); check_outs("up_c5", 1'b0, 1'b0, 1'b1);
    tick(); check_outs("up_c6", 1'b0, 1'b0, 1'b0);
    tick(); check_outs("up_c7", 1'b0, 1'b0, 1'b0);

    // Both held at par_out=5: round-robin UP, DOWN, UP, DOWN
    do_reset();
    par_fixed    = 4'd5;
    bus.up_req   = 1'b1;
    bus.down_req = 1'b1;
    tick(); check_outs("rr1", 1'b1, 1'b0, 1'b1);
    tick(); tick();
    tick(); check_outs("rr2", 1'b0, 1'b1, 1'b1);
    tick(); tick();
    tick(); check_outs("rr3", 1'b1, 1'b0, 1'b1);
    tick(); tick();
    tick(); check_outs("rr4", 1'b0, 1'b1, 1'b1);

    // Full counter refuses increments
    do_reset();
    par_fixed  = 4'd15;
    bus.up_req = 1'b1;
    #1;
    check("full_flag", 32'(bus.full),  32'd1);
    check("full_empty", 32'(bus.empty), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_outs("full_blk", 1'b0, 1'b0, 1'b0);
    end
`ifdef COUNTER_CTRL_ERR_EN
    check("full_err", 32'(bus.err), 32'd1);
`endif

    // Empty counter: down blocked, up granted
    do_reset();
`ifdef COUNTER_CTRL_ERR_EN
    check("err_cleared", 32'(bus.err), 32'd0);
`endif
    par_fixed    = 4'd0;
    bus.up_req   = 1'b1;
    bus.down_req = 1'b1;
    #1;
    check("empty_flag", 32'(bus.empty), 32'd1);
    check("empty_full", 32'(bus.full),  32'd0);
    tick(); check_outs("empty_c1", 1'b1, 1'b0, 1'b1);
    tick(); tick();
    tick(); check_outs("empty_c4", 1'b1, 1'b0, 1'b1);
`ifdef COUNTER_CTRL_ERR_EN
    check("empty_err", 32'(bus.err), 32'd1);
`endif

    // Reset asserted mid-GRANT clears outputs at once; next tie goes UP
    do_reset();
    par_fixed    = 4'd5;
    bus.up_req   = 1'b1;
    bus.down_req = 1'b0;
    tick(); check_outs("pre_rst", 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    check_outs("mid_rst", 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("in_rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    bus.down_req = 1'b1;
    tick(); check_outs("post_rst_tie", 1'b1, 1'b0, 1'b1);

    // Random requests against the counter model
    do_reset();
    tick();
    use_model = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus.up_req   = 1'($urandom_range(0, 1));
      bus.down_req = 1'($urandom_range(0, 1));
      tick();
      check("rnd_excl", 32'(bus.up_cnt_en & bus.down_cnt_en), 32'd0);
      check("rnd_range", 32'(model_cnt <= 5'd15), 32'd1);
    end
    use_model    = 1'b0;
    bus.up_req   = 1'b0;
    bus.down_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
